shift_reg_seq: RTL and testbench
================================

Name: shift_reg_seq

Overview:
Parametrised successor to the 8-bit mode-select shift register. It holds a WIDTH-bit word and executes a multi-bit shift or rotate sequentially, one bit per enabled cycle. A start/busy/done handshake sequences each operation, and a serial port provides fill and spill. It sits in the shifter library as the generic datapath shifter for the serial/parallel conversion blocks.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, $clog2(WIDTH+1), width of the shift-amount field (default 4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset; reset==0 at a clk edge clears all state
enable  input  1  step qualifier; when low, an operation in progress stalls
start  input  1  request pulse; accepted only in IDLE
mode  input  3  operation code, sampled at accept
amount  input  AMT_W  number of single-bit steps, sampled at accept
data_in  input  WIDTH  parallel load value (LOAD mode only)
serial_in  input  1  fill bit for SLS/SRS, sampled on every step
data_out  output  WIDTH  register contents
serial_out  output  1  last bit shifted or rotated out
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0 at edge): data_out=0, serial_out=0, state=IDLE, busy=0, done=0, count=0. Reset wins over every other input, including mid-RUN; the operation in progress is abandoned.
- Mode codes:
  - 000 LOAD
  - 001 SHL logical (fill 0)
  - 010 SHR logical (fill 0)
  - 011 SAR (fill MSB)
  - 100 ROL
  - 101 ROR
  - 110 SLS (shift left, fill serial_in at LSB)
  - 111 SRS (shift right, fill serial_in at MSB)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start==1 at edge E0 accepts the request, regardless of enable.
  - LOAD: data_out<=data_in, serial_out<=0, next state DONE. amount is ignored.
  - Other modes: latch mode; count<=min(amount,WIDTH).
    - count==0: next state DONE, data unchanged.
    - Otherwise: next state RUN.
- RUN:
  - On each edge with enable==1: apply one step, capture the spilled bit into serial_out, count<=count-1.
  - The step that brings count from 1 to 0 also moves state to DONE.
  - enable==0: hold everything; no step, count unchanged.
  - Spilled bit: left ops spill the MSB, right ops spill the LSB. ROL/ROR spill the bit that wraps around.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE; no queueing.
- Latency: with enable held high, steps occur on edges E1..EN and done is high in the cycle after EN. Back-to-back requests are possible with start asserted in the first IDLE cycle after done.
- amount > WIDTH clamps to WIDTH. A shift by WIDTH yields all-fill; a rotate by WIDTH yields the original word.
- data_out is stable between steps and valid when done is high.

Decomposition:
- Package shift_seq_pkg holds:
  - mode enum mode_e (LOAD, SHL, SHR, SAR, ROL, ROR, SLS, SRS; 3-bit)
  - state enum state_e (IDLE, RUN, DONE)
  - clamp function amt_clamp
- One sub-module, shift_step_unit: purely combinational single-bit step. Inputs word, mode, serial_in; outputs next word and spill bit. The top-level holds the FSM, counter and registers.

Test Plan:
- Reset with reset==0 during an active RUN of SHL by 5 -> next cycle data_out=0x00, serial_out=0, busy=0, done=0; a subsequent start is accepted normally.
- LOAD data_in=0xB5, then SHL amount=3 with enable=1 -> data_out=0xA8, serial_out=1, done high exactly 4 cycles after accept.
- LOAD 0xB5, SAR amount=2 -> data_out=0xED, serial_out=0. Then ROR amount=4 from 0xB5 -> data_out=0x5B.
- LOAD 0xB5, SRS amount=3 with serial_in=1 -> data_out=0xF6. Same with enable low for 2 cycles mid-RUN -> identical result, done delayed by 2 cycles.
- amount=0 with mode SHL -> done one cycle after accept, data_out unchanged. amount=15 with ROL -> clamps to 8, data_out=original, done after 9 cycles.
- start asserted while busy=1 -> ignored, with no change to mode or count. start in the first IDLE cycle after done -> accepted.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the sequential shift register.
//   mode_e     : 3-bit operation code carried on the mode input
//   state_e    : sequencing FSM states
//   amt_clamp  : limits a requested step count to the register width
package shift_seq_pkg;

   typedef enum logic [2:0] {
      LOAD = 3'b000,
      SHL  = 3'b001,
      SHR  = 3'b010,
      SAR  = 3'b011,
      ROL  = 3'b100,
      ROR  = 3'b101,
      SLS  = 3'b110,
      SRS  = 3'b111
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // More than width steps never changes the outcome of a shift beyond
   // all-fill, and a full rotation restores the word, so width is the cap.
   function automatic int amt_clamp(input int amount, input int width);
      return (amount > width) ? width : amount;
   endfunction

endpackage

// File: rtl/shift_reg_seq_if.sv
// Handshake and data bundle for shift_reg_seq.
//   master : requester side (drives enable/start/mode/amount/data_in/serial_in)
//   slave  : shifter side (drives data_out/serial_out/busy/done)
interface shift_reg_seq_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH + 1)
);
   logic             enable;
   logic             start;
   logic [2:0]       mode;
   logic [AMT_W-1:0] amount;
   logic [WIDTH-1:0] data_in;
   logic             serial_in;
   logic [WIDTH-1:0] data_out;
   logic             serial_out;
   logic             busy;
   logic             done;

   modport master (
      output enable, start, mode, amount, data_in, serial_in,
      input  data_out, serial_out, busy, done
   );

   modport slave (
      input  enable, start, mode, amount, data_in, serial_in,
      output data_out, serial_out, busy, done
   );
endinterface

// File: rtl/shift_step_unit.sv
// Combinational single-bit step of a shift or rotate.
//   word      : current register contents
//   mode      : operation code (LOAD passes the word through, spill 0)
//   serial_in : fill bit for SLS/SRS
//   next_word : word after one step
//   spill     : bit moved out (MSB for left ops, LSB for right ops)
module shift_step_unit
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] word,
   input  mode_e            mode,
   input  logic             serial_in,
   output logic [WIDTH-1:0] next_word,
   output logic             spill
);

   always_comb begin
      next_word = word;
      spill     = 1'b0;
      case (mode)
         SHL: begin
            next_word = {word[WIDTH-2:0], 1'b0};
            spill     = word[WIDTH-1];
         end
         SHR: begin
            next_word = {1'b0, word[WIDTH-1:1]};
            spill     = word[0];
         end
         SAR: begin
            next_word = {word[WIDTH-1], word[WIDTH-1:1]};
            spill     = word[0];
         end
         ROL: begin
            next_word = {word[WIDTH-2:0], word[WIDTH-1]};
            spill     = word[WIDTH-1];
         end
         ROR: begin
            next_word = {word[0], word[WIDTH-1:1]};
            spill     = word[0];
         end
         SLS: begin
            next_word = {word[WIDTH-2:0], serial_in};
            spill     = word[WIDTH-1];
         end
         SRS: begin
            next_word = {serial_in, word[WIDTH-1:1]};
            spill     = word[0];
         end
         default: begin
            next_word = word;
            spill     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_seq.sv
// Sequential WIDTH-bit shift/rotate register with start/busy/done handshake.
// A request is accepted in IDLE; LOAD completes immediately, other modes
// perform min(amount, WIDTH) single-bit steps, one per cycle with enable high.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset, clears all state
//   bus   : slave side of shift_reg_seq_if (request inputs, data/status outputs)
module shift_reg_seq
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   shift_reg_seq_if.slave bus
);

   state_e           state_q, state_d;
   mode_e            mode_q,  mode_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             sout_q,  sout_d;

   logic [WIDTH-1:0] step_word;
   logic             step_spill;
   int               req_steps;

   shift_step_unit #(.WIDTH(WIDTH)) u_step (
      .word      (data_q),
      .mode      (mode_q),
      .serial_in (bus.serial_in),
      .next_word (step_word),
      .spill     (step_spill)
   );

   assign req_steps = amt_clamp(int'(bus.amount), WIDTH);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      data_d  = data_q;
      sout_d  = sout_q;
      case (state_q)
         IDLE: begin
            // Acceptance does not depend on enable.
            if (bus.start) begin
               if (mode_e'(bus.mode) == LOAD) begin
                  data_d  = bus.data_in;
                  sout_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  mode_d  = mode_e'(bus.mode);
                  count_d = AMT_W'(req_steps);
                  state_d = (req_steps == 0) ? DONE : RUN;
               end
            end
         end
         RUN: begin
            if (bus.enable) begin
               data_d  = step_word;
               sout_d  = step_spill;
               count_d = count_q - AMT_W'(1);
               if (count_q == AMT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         mode_q  <= LOAD;
         count_q <= '0;
         data_q  <= '0;
         sout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         data_q  <= data_d;
         sout_q  <= sout_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.serial_out = sout_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq (WIDTH = 8).
module tb_shift_reg_seq;
   import shift_seq_pkg::*;

   localparam int WIDTH = 8;
   localparam int AMT_W = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;

   shift_reg_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

   shift_reg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: whole-operation arithmetic on the stored word.
   int exp_word = 0;
   int exp_sout = 0;

   function automatic int bit_of(input int w, input int k);
      return (w >> k) & 1;
   endfunction

   // Applies a whole request to the reference; returns clock edges from the
   // accept edge until done is visible (LOAD or zero steps: 1, else n+1).
   function automatic int model_op(input int m, input int amt, input int din, input int sin);
      int w, n, r, sp;
      logic signed [7:0] s8;
      w = exp_word;
      if (m == 0) begin
         exp_word = din & 255;
         exp_sout = 0;
         return 1;
      end
      n = (amt > WIDTH) ? WIDTH : amt;
      if (n == 0) return 1;
      r = w;
      sp = 0;
      case (m)
         1: begin r = (w << n) & 255;                     sp = bit_of(w, 8 - n); end
         2: begin r = w >> n;                             sp = bit_of(w, n - 1); end
         3: begin s8 = w[7:0]; r = int'(s8 >>> n) & 255;  sp = bit_of(w, n - 1); end
         4: begin r = ((w << n) | (w >> (8 - n))) & 255;  sp = bit_of(r, 0); end
         5: begin r = ((w >> n) | (w << (8 - n))) & 255;  sp = bit_of(r, 7); end
         6: begin r = ((w << n) | (sin != 0 ? (1 << n) - 1 : 0)) & 255;         sp = bit_of(w, 8 - n); end
         default: begin r = ((w >> n) | (sin != 0 ? (255 << (8 - n)) : 0)) & 255; sp = bit_of(w, n - 1); end
      endcase
      exp_word = r;
      exp_sout = sp;
      return n + 1;
   endfunction

   // Starts a request at a negedge and follows it through done and into the
   // first IDLE cycle, where it returns (so the next call is back-to-back).
   task automatic run_op(input string name, input int m, input int amt, input int din,
                         input int sin, input int en0, input int stall_at,
                         input int stall_len, input bit junk);
      int exp_lat, lat;
      exp_lat = model_op(m, amt, din, sin);
      if (exp_lat > 1 && stall_at >= 1 && stall_at <= exp_lat - 1) exp_lat += stall_len;
      bus.start     = 1'b1;
      bus.mode      = m[2:0];
      bus.amount    = amt[AMT_W-1:0];
      bus.data_in   = din[7:0];
      bus.serial_in = sin[0];
      bus.enable    = en0[0];
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 100) begin
         bus.enable = !(lat >= stall_at && lat < stall_at + stall_len);
         if (junk) begin
            bus.start   = 1'b1;
            bus.mode    = 3'($urandom);
            bus.amount  = 4'($urandom);
            bus.data_in = 8'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      bus.start  = 1'b0;
      bus.enable = 1'b1;
      n_chk++;
      if (lat !== exp_lat) $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
      else n_pass++;
      n_chk++;
      if (bus.data_out !== exp_word[7:0]) $display("FAIL %s data_out: got %h, expected %h", name, bus.data_out, exp_word[7:0]);
      else n_pass++;
      n_chk++;
      if (bus.serial_out !== exp_sout[0]) $display("FAIL %s serial_out: got %b, expected %b", name, bus.serial_out, exp_sout[0]);
      else n_pass++;
      n_chk++;
      if (bus.busy !== 1'b1) $display("FAIL %s busy_at_done: got %b, expected 1", name, bus.busy);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({bus.done, bus.busy} !== 2'b00) $display("FAIL %s idle_after_done: got done/busy %b, expected 00", name, {bus.done, bus.busy});
      else n_pass++;
   endtask

   task automatic test_reset();
      bus.enable = 1'b1; bus.start = 1'b0; bus.mode = 3'd0; bus.amount = '0;
      bus.data_in = '0; bus.serial_in = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      n_chk++;
      if ({bus.data_out, bus.serial_out, bus.busy, bus.done} !== 11'd0)
         $display("FAIL reset_state: got data %h sout %b busy %b done %b, expected all 0",
                  bus.data_out, bus.serial_out, bus.busy, bus.done);
      else n_pass++;
      exp_word = 0; exp_sout = 0;
   endtask

   task automatic test_reset_mid_run();
      run_op("load_b5", 0, 0, 'hB5, 0, 1, 0, 0, 0);
      bus.start = 1'b1; bus.mode = 3'd1; bus.amount = 4'd5; bus.enable = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_chk++;
      if ({bus.data_out, bus.serial_out, bus.busy, bus.done} !== 11'd0)
         $display("FAIL reset_mid_run: got data %h sout %b busy %b done %b, expected all 0",
                  bus.data_out, bus.serial_out, bus.busy, bus.done);
      else n_pass++;
      exp_word = 0; exp_sout = 0;
      run_op("load_after_reset", 0, 0, 'h3C, 0, 0, 0, 0, 0);
   endtask

   task automatic test_plan_vectors();
      run_op("load_b5", 0, 0, 'hB5, 0, 1, 0, 0, 0);
      run_op("shl3", 1, 3, 0, 0, 1, 0, 0, 0);
      run_op("load_b5", 0, 0, 'hB5, 0, 1, 0, 0, 0);
      run_op("sar2", 3, 2, 0, 0, 1, 0, 0, 0);
      run_op("load_b5", 0, 0, 'hB5, 0, 1, 0, 0, 0);
      run_op("ror4", 5, 4, 0, 0, 1, 0, 0, 0);
      run_op("load_b5", 0, 0, 'hB5, 0, 1, 0, 0, 0);
      run_op("srs3", 7, 3, 0, 1, 1, 0, 0, 0);
   endtask

   task automatic test_stall();
      run_op("load_b5", 0, 0, 'hB5, 0, 1, 0, 0, 0);
      run_op("srs3_stall", 7, 3, 0, 1, 1, 2, 2, 0);
   endtask

   task automatic test_clamp_zero();
      run_op("load_5a", 0, 0, 'h5A, 0, 1, 0, 0, 0);
      run_op("shl0", 1, 0, 0, 0, 1, 0, 0, 0);
      run_op("rol15", 4, 15, 0, 0, 1, 0, 0, 0);
      run_op("shr8", 2, 8, 0, 0, 1, 0, 0, 0);
      run_op("load_81", 0, 0, 'h81, 0, 0, 0, 0, 0);
      run_op("sls12", 6, 12, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic test_busy_start();
      run_op("load_c3", 0, 0, 'hC3, 0, 1, 0, 0, 0);
      run_op("rol5_junk", 4, 5, 0, 0, 1, 0, 0, 1);
      run_op("sar7_junk", 3, 7, 0, 0, 0, 3, 1, 1);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_load", 0, 0, 'h96, 0, 1, 0, 0, 0);
      run_op("b2b_ror1", 5, 1, 0, 0, 1, 0, 0, 0);
      run_op("b2b_sls2", 6, 2, 0, 0, 1, 0, 0, 0);
      run_op("b2b_shr0", 2, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_plan_vectors();
      test_stall();
      test_clamp_zero();
      test_busy_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
